// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: counts occurrences of a configurable bit pattern within a window of stream bits.
// Define MATCH_OVERLAP_EN to count overlapping matches; by default each match consumes its bits.
module pattern_scan_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int WIN_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [MAX_LEN-1:0]             pat,
    input  logic [$clog2(MAX_LEN+1)-1:0]   pat_len,
    input  logic [WIN_W-1:0]               win_len,
    input  logic                           data_valid,
    input  logic                           data_in,
    output logic                           busy,
    output logic                           match,
    output logic [CNT_W-1:0]               match_cnt,
    output logic                           done,
    output logic                           err
);

    localparam int PL_W = $clog2(MAX_LEN+1);
    localparam logic [PL_W-1:0] MAX_LEN_PL = PL_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e               state_q, state_d;
    logic [MAX_LEN-1:0]   pat_q, pat_d;
    logic [PL_W-1:0]      patLen_q, patLen_d;
    logic [WIN_W-1:0]     winLen_q, winLen_d;
    logic [MAX_LEN-1:0]   history_q, history_d;
    logic [PL_W-1:0]      bitsSeen_q, bitsSeen_d;
    logic [WIN_W-1:0]     bitCnt_q, bitCnt_d;
    logic [CNT_W-1:0]     matchCnt_q, matchCnt_d;
    logic                 match_q, match_d;
    logic                 err_q, err_d;

    logic                 cfgValid;
    logic                 accept;
    logic                 hit;
    logic                 lastBit;
    logic [MAX_LEN-1:0]   candidate;
    logic [MAX_LEN-1:0]   lenMask;
    logic [PL_W:0]        seenPlus;
    logic [PL_W-1:0]      seenSat;

    assign cfgValid = (pat_len != '0) && (pat_len <= MAX_LEN_PL) && (win_len != '0);
    // An abort discards whatever bit arrives in the same cycle.
    assign accept   = (state_q == SCAN) && data_valid && !abort;
    assign lastBit  = (bitCnt_q + WIN_W'(1)) == winLen_q;

    always_comb begin
        lenMask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lenMask[i] = PL_W'(i) < patLen_q;
        end
        candidate = MAX_LEN'({history_q, data_in});
        seenPlus  = {1'b0, bitsSeen_q} + (PL_W+1)'(1);
        seenSat   = (bitsSeen_q == MAX_LEN_PL) ? bitsSeen_q : bitsSeen_q + PL_W'(1);
        hit       = accept && (seenPlus >= {1'b0, patLen_q}) &&
                    (((candidate ^ pat_q) & lenMask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && cfgValid) state_d = SCAN;
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (data_valid && lastBit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == SCAN);
        done      = (state_q == DONE);
        match     = match_q;
        err       = err_q;
        match_cnt = matchCnt_q;
    end

    always_comb begin
        pat_d      = pat_q;
        patLen_d   = patLen_q;
        winLen_d   = winLen_q;
        history_d  = history_q;
        bitsSeen_d = bitsSeen_q;
        bitCnt_d   = bitCnt_q;
        matchCnt_d = matchCnt_q;
        match_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfgValid) begin
                        pat_d      = pat;
                        patLen_d   = pat_len;
                        winLen_d   = win_len;
                        history_d  = '0;
                        bitsSeen_d = '0;
                        bitCnt_d   = '0;
                        matchCnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (accept) begin
                    bitCnt_d   = bitCnt_q + WIN_W'(1);
                    history_d  = candidate;
                    bitsSeen_d = seenSat;
                    if (hit) begin
                        match_d = 1'b1;
                        if (matchCnt_q != '1) matchCnt_d = matchCnt_q + CNT_W'(1);
`ifdef MATCH_OVERLAP_EN
                        history_d  = candidate;
                        bitsSeen_d = seenSat;
`else
                        history_d  = '0;
                        bitsSeen_d = '0;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q      <= '0;
            patLen_q   <= '0;
            winLen_q   <= '0;
            history_q  <= '0;
            bitsSeen_q <= '0;
            bitCnt_q   <= '0;
            matchCnt_q <= '0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pat_q      <= pat_d;
            patLen_q   <= patLen_d;
            winLen_q   <= winLen_d;
            history_q  <= history_d;
            bitsSeen_q <= bitsSeen_d;
            bitCnt_q   <= bitCnt_d;
            matchCnt_q <= matchCnt_d;
            match_q    <= match_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl; expectations follow MATCH_OVERLAP_EN if it is defined.
module tb_pattern_scan_ctrl;

    typedef struct {
        logic        start;
        logic        abort;
        logic        dv;
        logic        din;
        logic [3:0]  patLen;
        logic [15:0] winLen;
        logic        expBusy;
        logic        expMatch;
        logic        expDone;
        logic        expErr;
        logic [7:0]  expCnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  pat;
    logic [3:0]  patLen;
    logic [15:0] winLen;
    logic        dataValid;
    logic        dataIn;
    logic        busy;
    logic        match;
    logic [7:0]  matchCnt;
    logic        done;
    logic        err;

    logic        sStart;
    logic        sDataValid;
    logic        sDataIn;
    logic        sBusy;
    logic        sMatch;
    logic [1:0]  sMatchCnt;
    logic        sDone;
    logic        sErr;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    // Stream 1,0,1,1,0,1,1,0,1,1,0,0 with pattern 1011; hit positions worked out by hand.
    int streamBits[12] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
`ifdef MATCH_OVERLAP_EN
    int hitBits[12]    = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
`else
    int hitBits[12]    = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
`endif

    pattern_scan_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pat        (pat),
        .pat_len    (patLen),
        .win_len    (winLen),
        .data_valid (dataValid),
        .data_in    (dataIn),
        .busy       (busy),
        .match      (match),
        .match_cnt  (matchCnt),
        .done       (done),
        .err        (err)
    );

    pattern_scan_ctrl #(.CNT_W(2)) satDut (
        .clk        (clk),
        .rst        (rst),
        .start      (sStart),
        .abort      (1'b0),
        .pat        (8'h01),
        .pat_len    (4'd1),
        .win_len    (16'd6),
        .data_valid (sDataValid),
        .data_in    (sDataIn),
        .busy       (sBusy),
        .match      (sMatch),
        .match_cnt  (sMatchCnt),
        .done       (sDone),
        .err        (sErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareField(input string tag, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%0d expected=%0d", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expBusy, input logic expMatch,
                               input logic expDone, input logic expErr, input logic [7:0] expCnt);
        compareField(tag, "busy", int'(busy), int'(expBusy));
        compareField(tag, "match", int'(match), int'(expMatch));
        compareField(tag, "done", int'(done), int'(expDone));
        compareField(tag, "err", int'(err), int'(expErr));
        compareField(tag, "match_cnt", int'(matchCnt), int'(expCnt));
    endtask

    task automatic checkSat(input string tag, input logic expBusy, input logic expMatch,
                            input logic expDone, input logic [1:0] expCnt);
        compareField(tag, "sat.busy", int'(sBusy), int'(expBusy));
        compareField(tag, "sat.match", int'(sMatch), int'(expMatch));
        compareField(tag, "sat.done", int'(sDone), int'(expDone));
        compareField(tag, "sat.err", int'(sErr), 0);
        compareField(tag, "sat.match_cnt", int'(sMatchCnt), int'(expCnt));
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then sample 1 time unit later.
    task automatic applyStimulus(input logic st, input logic ab, input logic dv, input logic di,
                                 input logic [3:0] pl, input logic [15:0] wl);
        start     = st;
        abort     = ab;
        dataValid = dv;
        dataIn    = di;
        patLen    = pl;
        winLen    = wl;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic st, input logic ab, input logic dv, input logic di,
                          input logic [3:0] pl, input logic [15:0] wl, input logic eb,
                          input logic em, input logic ed, input logic ee, input logic [7:0] ec);
        vec_t v;
        v.start = st;  v.abort = ab;  v.dv = dv;  v.din = di;
        v.patLen = pl; v.winLen = wl;
        v.expBusy = eb; v.expMatch = em; v.expDone = ed; v.expErr = ee; v.expCnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int runCnt;
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; dataValid = 1'b0; dataIn = 1'b0;
        pat = 8'b0000_1011; patLen = 4'd4; winLen = 16'd12;
        sStart = 1'b0; sDataValid = 1'b0; sDataIn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        checkSat("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;

        // Contiguous scan, start ignored in DONE, back-to-back start in IDLE.
        runCnt = 0;
        addVec(1, 0, 0, 0, 4, 12, 1, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            if (hitBits[k] != 0) runCnt++;
            addVec(0, 0, 1, streamBits[k] != 0, 4, 12, k < 11, hitBits[k] != 0, k == 11, 0, 8'(runCnt));
        end
        addVec(1, 0, 0, 0, 4, 12, 0, 0, 0, 0, 8'(runCnt));
        runCnt = 0;
        addVec(1, 0, 0, 0, 4, 12, 1, 0, 0, 0, 0);
        // Same scan with data_valid low every other cycle and junk on the idle cycles.
        for (int k = 0; k < 12; k++) begin
            addVec(0, 0, 0, streamBits[k] == 0, 4, 12, 1, 0, 0, 0, 8'(runCnt));
            if (hitBits[k] != 0) runCnt++;
            addVec(0, 0, 1, streamBits[k] != 0, 4, 12, k < 11, hitBits[k] != 0, k == 11, 0, 8'(runCnt));
        end
        addVec(0, 0, 0, 0, 4, 12, 0, 0, 0, 0, 8'(runCnt));
        // Rejected configurations.
        addVec(1, 0, 0, 0, 0, 12, 0, 0, 0, 1, 8'(runCnt));
        addVec(0, 0, 0, 0, 4, 12, 0, 0, 0, 0, 8'(runCnt));
        addVec(1, 0, 0, 0, 9, 12, 0, 0, 0, 1, 8'(runCnt));
        addVec(0, 0, 0, 0, 4, 12, 0, 0, 0, 0, 8'(runCnt));
        addVec(1, 0, 0, 0, 4, 0, 0, 0, 0, 1, 8'(runCnt));
        addVec(0, 0, 0, 0, 4, 12, 0, 0, 0, 0, 8'(runCnt));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].dv, vecs[i].din,
                          vecs[i].patLen, vecs[i].winLen);
            checkOutput($sformatf("vec%0d", i), vecs[i].expBusy, vecs[i].expMatch,
                        vecs[i].expDone, vecs[i].expErr, vecs[i].expCnt);
        end

        // Abort with start after six bits; the seventh bit would complete an overlapping match.
        applyStimulus(1, 0, 0, 0, 4, 12);
        checkOutput("abort.start", 1, 0, 0, 0, 8'd0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 1, streamBits[k] != 0, 4, 12);
            checkOutput($sformatf("abort.bit%0d", k + 1), 1, k == 3, 0, 0, (k >= 3) ? 8'd1 : 8'd0);
        end
        applyStimulus(1, 1, 1, 1, 4, 12);
        checkOutput("abort.cycle", 0, 0, 0, 0, 8'd1);
        applyStimulus(0, 0, 0, 0, 4, 12);
        checkOutput("abort.after", 0, 0, 0, 0, 8'd1);

        // Reset mid-scan overrides start and a valid bit.
        applyStimulus(1, 0, 0, 0, 4, 12);
        checkOutput("rst.start", 1, 0, 0, 0, 8'd0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 1, streamBits[k] != 0, 4, 12);
        end
        checkOutput("rst.before", 1, 0, 0, 0, 8'd1);
        rst = 1'b1;
        applyStimulus(1, 0, 1, 1, 4, 12);
        checkOutput("rst.cycle", 0, 0, 0, 0, 8'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 4, 12);
        checkOutput("rst.after", 0, 0, 0, 0, 8'd0);

        // Saturation on the 2-bit counter instance.
        sStart = 1'b1;
        @(posedge clk);
        #1;
        sStart = 1'b0;
        checkSat("sat.start", 1, 0, 0, 2'd0);
        for (int k = 1; k <= 6; k++) begin
            sDataValid = 1'b1;
            sDataIn    = 1'b1;
            @(posedge clk);
            #1;
            checkSat($sformatf("sat.bit%0d", k), k < 6, 1, k == 6, (k >= 3) ? 2'd3 : 2'(k));
        end
        sDataValid = 1'b0;
        @(posedge clk);
        #1;
        checkSat("sat.after", 0, 0, 0, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
